// File: rtl/key_onehot_capture.sv
// Turns eight asynchronous key lines into one-hot press tokens behind a valid/ready slot.
// The lines are synchronised and debounced together; only 0->1 transitions produce a token.
module key_onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys_in,
    input  logic       ready_in,
    output logic [7:0] onehot_out,
    output logic       valid_out,
    output logic       multi_out,
    output logic       drop_out
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync1, sync2, cand, deb, cnt;
    logic [0:0] state;
    logic       upd;
    logic [7:0] press, sel;
    logic       multi;

    // Debounced vector moves only once every line has been stable for DEBOUNCE_CYCLES samples
    assign upd   = (sync2 == cand) && (cnt == CNT_MAX) && (cand != deb);
    assign press = upd ? (cand & ~deb) : 8'h00;
    assign sel   = press & (~press + 8'h01);
    assign multi = (press & (press - 8'h01)) != 8'h00;

    assign valid_out = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
            cand  <= 8'h00;
            deb   <= 8'h00;
            cnt   <= 8'h00;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= 8'h00;
            end else if (cnt == CNT_MAX) begin
                if (cand != deb)
                    deb <= cand;
            end else begin
                cnt <= cnt + 8'h01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            onehot_out <= 8'h00;
            multi_out  <= 1'b0;
            drop_out   <= 1'b0;
        end else begin
            multi_out <= multi;
            drop_out  <= 1'b0;
            case (state)
                EMPTY: begin
                    if (press != 8'h00) begin
                        onehot_out <= sel;
                        state      <= FULL;
                    end
                end
                default: begin
                    if (ready_in) begin
                        // A press arriving on the transfer edge refills the slot with no valid gap
                        if (press != 8'h00) begin
                            onehot_out <= sel;
                        end else begin
                            onehot_out <= 8'h00;
                            state      <= EMPTY;
                        end
                    end else if (press != 8'h00) begin
                        drop_out <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with DEBOUNCE_CYCLES=4 (7-edge press latency).
module tb_key_onehot_capture;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys_in;
    logic       ready_in;
    logic [7:0] onehot_out;
    logic       valid_out, multi_out, drop_out;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int multi_cnt = 0;
    logic seen_valid;

    key_onehot_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .keys_in(keys_in), .ready_in(ready_in),
        .onehot_out(onehot_out), .valid_out(valid_out),
        .multi_out(multi_out), .drop_out(drop_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drop_out) drop_cnt++;
        if (multi_out) multi_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; keys_in = 8'h00; ready_in = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_onehot", onehot_out, 8'h00);
        chk("rst_valid", {7'b0, valid_out}, 8'h00);
        chk("rst_multi", {7'b0, multi_out}, 8'h00);
        chk("rst_drop", {7'b0, drop_out}, 8'h00);

        // single press, 7-edge latency, held under back-pressure
        keys_in = 8'h20;
        step(6);
        chk("single_early", {7'b0, valid_out}, 8'h00);
        step(1);
        chk("single_valid", {7'b0, valid_out}, 8'h01);
        chk("single_onehot", onehot_out, 8'h20);
        chk("single_multi", {7'b0, multi_out}, 8'h00);
        step(5);
        chk("single_hold", onehot_out, 8'h20);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        chk("single_xfer_valid", {7'b0, valid_out}, 8'h00);
        chk("single_xfer_onehot", onehot_out, 8'h00);

        // release-only produces nothing
        keys_in = 8'h00;
        step(12);
        chk("release_valid", {7'b0, valid_out}, 8'h00);

        // bounce on bit 3
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keys_in = (i % 2 == 0) ? 8'h08 : 8'h00;
            for (int j = 0; j < 2; j++) begin
                step(1);
                if (valid_out) seen_valid = 1'b1;
            end
        end
        chk("bounce_quiet", {7'b0, seen_valid}, 8'h00);
        keys_in = 8'h08;
        step(6);
        chk("bounce_early", {7'b0, valid_out}, 8'h00);
        step(1);
        chk("bounce_valid", {7'b0, valid_out}, 8'h01);
        chk("bounce_onehot", onehot_out, 8'h08);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        keys_in = 8'h00;
        step(12);

        // simultaneous press: lowest index wins, multi pulses with valid
        multi_cnt = 0;
        keys_in = 8'h24;
        step(6);
        chk("multi_early", {7'b0, valid_out}, 8'h00);
        step(1);
        chk("multi_valid", {7'b0, valid_out}, 8'h01);
        chk("multi_onehot", onehot_out, 8'h04);
        chk("multi_pulse", {7'b0, multi_out}, 8'h01);
        step(1);
        chk("multi_pulse_end", {7'b0, multi_out}, 8'h00);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        keys_in = 8'h00;
        step(12);
        chk("multi_count", 8'(multi_cnt), 8'h01);

        // back-pressure drop, then refill on the transfer edge
        drop_cnt = 0;
        keys_in = 8'h02;
        step(7);
        chk("bp_onehot", onehot_out, 8'h02);
        keys_in = 8'h82;
        step(7);
        chk("bp_drop", {7'b0, drop_out}, 8'h01);
        chk("bp_hold", onehot_out, 8'h02);
        step(1);
        chk("bp_drop_end", {7'b0, drop_out}, 8'h00);
        keys_in = 8'h02;
        step(12);
        keys_in = 8'h82;
        seen_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (!valid_out) seen_valid = 1'b0;
        end
        ready_in = 1'b1;
        step(1);
        if (!valid_out) seen_valid = 1'b0;
        ready_in = 1'b0;
        chk("refill_onehot", onehot_out, 8'h80);
        step(2);
        if (!valid_out) seen_valid = 1'b0;
        chk("refill_no_gap", {7'b0, seen_valid}, 8'h01);
        chk("bp_drop_count", 8'(drop_cnt), 8'h01);

        // reset while valid, keys held through reset
        rst = 1'b1;
        step(1);
        chk("mid_rst_valid", {7'b0, valid_out}, 8'h00);
        chk("mid_rst_onehot", onehot_out, 8'h00);
        chk("mid_rst_drop", {7'b0, drop_out}, 8'h00);
        rst = 1'b0;
        step(6);
        chk("held_early", {7'b0, valid_out}, 8'h00);
        step(1);
        chk("held_valid", {7'b0, valid_out}, 8'h01);
        chk("held_onehot", onehot_out, 8'h02);
        chk("held_multi", {7'b0, multi_out}, 8'h01);
        ready_in = 1'b1;
        keys_in = 8'h00;
        step(1);
        chk("final_xfer", {7'b0, valid_out}, 8'h00);
        step(12);
        chk("final_idle", {7'b0, valid_out}, 8'h00);
        chk("final_drop_count", 8'(drop_cnt), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_onehot_capture.md
# key_onehot_capture

Synchronises, debounces and edge-detects eight asynchronous key or strobe lines and presents each new press as a single one-hot byte behind a valid/ready handshake. It sits directly upstream of the 8-to-3 encoder. Its one-hot output is guaranteed to have exactly one bit set whenever valid, so the encoder's default branch is never exercised. Diagnostic pulses flag simultaneous presses and presses lost to back-pressure.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required before the debounced vector updates; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- keys_in  input  8  asynchronous key lines, active-high; bit i is key i.
- ready_in  input  1  downstream (encoder side) accepts onehot_out this cycle.
- onehot_out  output  8  captured press, exactly one bit set while valid_out=1; 8'h00 when empty.
- valid_out  output  1  onehot_out holds an unconsumed press.
- multi_out  output  1  one-cycle pulse: more than one key pressed in the same debounced update.
- drop_out  output  1  one-cycle pulse: press discarded because slot full and not consumed.

## Operation
- Synchroniser: two flops per bit (sync1, sync2); no logic between them.
- Debounce (shared across all 8 bits), registers cand[7:0], deb[7:0], cnt[7:0]:
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - sync2 == cand and cnt == DEBOUNCE_CYCLES-1 and cand != deb: deb <= cand (update event).
  - sync2 == cand otherwise: cnt increments, saturating at DEBOUNCE_CYCLES-1.
- Press vector at update event: press = cand & ~deb. Releases (1->0) update deb but never generate output.
- Selection: if press has more than one bit set, the lowest index wins; multi_out pulses. Other simultaneous presses are discarded.
- Slot FSM, states EMPTY / FULL:
  - EMPTY + press != 0: load onehot_out, go to FULL.
  - FULL + valid_out & ready_in, no press: clear onehot_out to 0, go to EMPTY.
  - FULL + valid_out & ready_in + press: load the new press, stay FULL. Valid stays high with no gap.
  - FULL + !ready_in + press: slot unchanged, drop_out pulses.
  - ready_in while EMPTY: no effect.
- onehot_out and valid_out are registered outputs, held stable while valid_out=1 and ready_in=0.
- multi_out and drop_out are registered and high for exactly one cycle per event. Both may pulse in the same cycle.

## Timing
- Reset: sync1, sync2, cand, deb, cnt, onehot_out = 0; valid_out = multi_out = drop_out = 0; FSM = EMPTY.
- Reset mid-operation: a pending press is lost, with no drop_out pulse. Keys held high through reset release are seen as new presses after release.
- Latency:
  - keys_in rises before edge E0 and stays stable: sync2 is new after E0+1, cand loads at E0+2, deb and slot update at E0+DEBOUNCE_CYCLES+2.
  - valid_out is therefore high DEBOUNCE_CYCLES+3 edges after the input change, counting E0 as edge 1 (7 for the default).
- Transfer completes on the edge where valid_out & ready_in are both 1. valid_out falls after that edge unless reloaded.
- Bounce: any sync2 change restarts cnt. A line toggling faster than DEBOUNCE_CYCLES produces no event.
- Throughput: at most one press per clock. Back-to-back presses need DEBOUNCE_CYCLES+1 cycles of input stability each.

## Test plan
- Single press, DEBOUNCE_CYCLES=4, ready_in=0: keys_in 00->20 -> onehot_out=8'h20, valid_out=1 exactly 7 edges later, held until ready_in=1, then 8'h00, valid_out=0 one edge after the transfer.
- Bounce: keys_in bit 3 toggles every 2 cycles for 20 cycles, then stays 1 -> no output during toggling; one onehot_out=8'h08 after 7 stable edges.
- Simultaneous: keys_in 00->24 in one cycle -> onehot_out=8'h04, multi_out one-cycle pulse in the same cycle valid_out rises.
- Back-pressure: key 1 captured with ready_in=0, then key 7 pressed -> drop_out pulses once, onehot_out stays 8'h02. Release and press key 7 again with ready_in=1 on the update edge -> onehot_out=8'h80, valid_out never deasserts.
- Release-only and reset: release all keys -> no valid_out. Assert rst for 1 cycle while valid_out=1 -> all outputs 0 next cycle. A key held through reset reappears after 7 edges.
